// File: rtl/calc_sequencer_if.sv
// Token, ALU and display signals of the calculator sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface calc_sequencer_if #(parameter int WIDTH = 16);
  logic [4:0]       i_data;
  logic             i_valid;
  logic             o_ready;
  logic             o_alu_start;
  logic [1:0]       o_alu_op;
  logic [WIDTH-1:0] o_alu_a;
  logic [WIDTH-1:0] o_alu_b;
  logic             i_alu_done;
  logic [WIDTH-1:0] i_alu_result;
  logic             i_alu_err;
  logic [WIDTH-1:0] o_display;
  logic             o_error;
  logic             o_busy;

  modport slave (
    input  i_data, i_valid, i_alu_done, i_alu_result, i_alu_err,
    output o_ready, o_alu_start, o_alu_op, o_alu_a, o_alu_b,
           o_display, o_error, o_busy
  );

  modport master (
    output i_data, i_valid, i_alu_done, i_alu_result, i_alu_err,
    input  o_ready, o_alu_start, o_alu_op, o_alu_a, o_alu_b,
           o_display, o_error, o_busy
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator control FSM: operand entry, operator latching and ALU sequencing.
// Optional macro CALC_CHAIN_OPS_EN: an operator typed after B executes the pending op.
//
// state   | meaning
// A_ENTRY | entering left operand A
// OP_WAIT | operator latched, waiting for first digit of B
// B_ENTRY | entering right operand B
// EXEC    | ALU operation in flight (start pulse on first cycle)
// RESULT  | result shown, A holds it
// ERROR   | ALU reported an error; only AC leaves
module calc_sequencer #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  calc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    A_ENTRY, OP_WAIT, B_ENTRY, EXEC, RESULT, ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic             err_q, err_d;
  logic             first_q, first_d;
`ifdef CALC_CHAIN_OPS_EN
  logic             chain_q, chain_d;
  logic [1:0]       chain_op_q, chain_op_d;
`endif

  logic [4:0]       tok;
  logic             accept;
  logic             is_digit, is_op, is_ac, is_eq;
  logic [1:0]       tok_op;
  logic [WIDTH-1:0] digit_w;
  logic [WIDTH-1:0] a_next, b_next;

  // Overflowing digits are dropped silently, leaving the operand untouched.
  function automatic logic [WIDTH-1:0] append_digit(input logic [WIDTH-1:0] acc,
                                                    input logic [3:0] d);
    logic [WIDTH+3:0] ext;
    ext = (WIDTH+4)'(acc) * (WIDTH+4)'(10) + (WIDTH+4)'(d);
    if (ext[WIDTH+3:WIDTH] != 4'd0) return acc;
    return ext[WIDTH-1:0];
  endfunction

  always_comb begin
    tok      = bus.i_data;
    accept   = bus.i_valid && (state_q != EXEC);
    is_digit = tok < 5'd10;
    is_op    = (tok >= 5'd17) && (tok <= 5'd20);
    is_ac    = tok == 5'd16;
    is_eq    = tok == 5'd21;
    tok_op   = 2'(tok - 5'd17);
    digit_w  = WIDTH'(tok[3:0]);
    a_next   = append_digit(a_q, tok[3:0]);
    b_next   = append_digit(b_q, tok[3:0]);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    disp_d  = disp_q;
    err_d   = err_q;
    first_d = 1'b0;
`ifdef CALC_CHAIN_OPS_EN
    chain_d    = chain_q;
    chain_op_d = chain_op_q;
`endif
    if (accept && is_ac) begin
      state_d = A_ENTRY;
      a_d     = '0;
      b_d     = '0;
      op_d    = 2'd0;
      disp_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        A_ENTRY: begin
          if (accept && is_digit) begin
            a_d    = a_next;
            disp_d = a_next;
          end else if (accept && is_op) begin
            op_d    = tok_op;
            state_d = OP_WAIT;
          end
        end
        OP_WAIT: begin
          if (accept && is_digit) begin
            b_d     = digit_w;
            disp_d  = digit_w;
            state_d = B_ENTRY;
          end else if (accept && is_op) begin
            op_d = tok_op;
          end else if (accept && is_eq) begin
            b_d     = a_q;
            state_d = EXEC;
            first_d = 1'b1;
          end
        end
        B_ENTRY: begin
          if (accept && is_digit) begin
            b_d    = b_next;
            disp_d = b_next;
          end else if (accept && is_eq) begin
            state_d = EXEC;
            first_d = 1'b1;
          end
`ifdef CALC_CHAIN_OPS_EN
          else if (accept && is_op) begin
            chain_d    = 1'b1;
            chain_op_d = tok_op;
            state_d    = EXEC;
            first_d    = 1'b1;
          end
`endif
        end
        EXEC: begin
          // Done in the start cycle cannot belong to this request.
          if (!first_q && bus.i_alu_done) begin
            if (bus.i_alu_err) begin
              err_d   = 1'b1;
              disp_d  = '0;
              state_d = ERROR;
            end else begin
              a_d     = bus.i_alu_result;
              disp_d  = bus.i_alu_result;
              state_d = RESULT;
`ifdef CALC_CHAIN_OPS_EN
              if (chain_q) begin
                op_d    = chain_op_q;
                state_d = OP_WAIT;
              end
`endif
            end
`ifdef CALC_CHAIN_OPS_EN
            chain_d = 1'b0;
`endif
          end
        end
        RESULT: begin
          if (accept && is_digit) begin
            a_d     = digit_w;
            disp_d  = digit_w;
            state_d = A_ENTRY;
          end else if (accept && is_op) begin
            op_d    = tok_op;
            state_d = OP_WAIT;
          end
        end
        ERROR: ;
        default: state_d = A_ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= A_ENTRY;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'd0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
`ifdef CALC_CHAIN_OPS_EN
      chain_q    <= 1'b0;
      chain_op_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      first_q <= first_d;
`ifdef CALC_CHAIN_OPS_EN
      chain_q    <= chain_d;
      chain_op_q <= chain_op_d;
`endif
    end
  end

  assign bus.o_ready     = state_q != EXEC;
  assign bus.o_busy      = state_q == EXEC;
  assign bus.o_alu_start = first_q;
  assign bus.o_alu_op    = op_q;
  assign bus.o_alu_a     = a_q;
  assign bus.o_alu_b     = b_q;
  assign bus.o_display   = disp_q;
  assign bus.o_error     = err_q;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Central control FSM of the calculator.
- Consumes key tokens from the button reader over a valid/ready handshake and assembles decimal operands.
- Latches the pending operator and issues operations to an external arithmetic unit through a start/done handshake.
- Holds the value to be displayed and the error flag.

Parameters:
- WIDTH, 16: operand, result and display width in bits; unsigned.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- i_data  input  5  key token
- i_valid  input  1  token valid
- o_ready  output  1  sequencer can accept a token
- o_alu_start  output  1  one-cycle pulse requesting an operation
- o_alu_op  output  2  operation: 0 add, 1 sub, 2 mul, 3 div
- o_alu_a  output  WIDTH  left operand
- o_alu_b  output  WIDTH  right operand
- i_alu_done  input  1  operation complete; result and error valid this cycle
- i_alu_result  input  WIDTH  operation result
- i_alu_err  input  1  operation error (divide by zero, overflow, underflow)
- o_display  output  WIDTH  value to show
- o_error  output  1  sticky error indicator
- o_busy  output  1  operation in flight

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
- Reset values: state A_ENTRY; accumulators, operator and o_alu_a/o_alu_b all 0; o_display 0; o_error 0; o_busy 0; o_alu_start 0; o_ready 1.
- Token encoding:
  - 0-9: digits.
  - 10-15: unused keypad keys; accepted and dropped.
  - 16 AC, 17 ADD, 18 SUB, 19 MUL, 20 DIV, 21 EQ.
  - 22-31: accepted and dropped.
- Handshake: a token is consumed on a cycle with i_valid & o_ready. o_ready = 0 only in EXEC. At most one token per cycle.
- Digit entry: acc <= acc*10 + d, computed in WIDTH+4 bits. If the result exceeds 2^WIDTH-1, the digit is dropped and acc is unchanged (no error). o_display tracks the operand being entered.
- States:
  - A_ENTRY
    - digit: updates A.
    - operator: latches op, -> OP_WAIT; display keeps A.
    - EQ: no effect.
  - OP_WAIT
    - digit: B = digit, -> B_ENTRY.
    - operator: replaces latched op.
    - EQ: B = A, -> EXEC.
  - B_ENTRY
    - digit: updates B.
    - EQ: -> EXEC.
    - operator: see Optional Feature.
  - EXEC
    - o_alu_start is high for exactly the first cycle; o_alu_a, o_alu_b and o_alu_op are held stable until done.
    - i_alu_done is ignored in the start cycle.
    - On done with err = 0: A = result, display = result, -> RESULT.
    - On done with err = 1: o_error = 1, display = 0, -> ERROR.
  - RESULT
    - digit: A = digit, -> A_ENTRY (new calculation).
    - operator: A retained, latch op, -> OP_WAIT.
    - EQ: no effect.
  - ERROR
    - Only AC has effect; all other tokens are accepted and dropped.
- AC, in any state except EXEC: clears A, B, op, display and o_error in the same cycle; -> A_ENTRY. The clear is visible the cycle after acceptance.
- o_busy = 1 exactly while in EXEC.
- i_alu_done outside EXEC is ignored.
- Reset asserted during EXEC aborts the operation. A late i_alu_done after reset is ignored.
- Simultaneous token valid and ALU done in EXEC: the token is not consumed (o_ready = 0); done is processed.

Optional Feature:
- Macro: CALC_CHAIN_OPS_EN.
- Defined: an operator in B_ENTRY executes the pending operation (-> EXEC). On success, A = result, the new operator is latched, and the state returns to OP_WAIT, not RESULT. On error, -> ERROR as normal.
- Not defined: an operator in B_ENTRY is accepted and ignored; only EQ executes.

Test Plan:
- Tokens 1,2,ADD,3,4,EQ; ALU returns 46 two cycles after start -> o_alu_a=12, o_alu_b=34, o_alu_op=0, one start pulse, o_display=46, o_busy low after done, o_ready high.
- 7,DIV,0,EQ; ALU returns err=1 -> o_error=1, o_display=0. Subsequent 5 ignored. AC -> o_error=0, o_display=0.
- WIDTH=16: 6,5,5,3,5, then 9 -> display 65535, digit 9 dropped, no error.
- i_valid held high with ADD token during EXEC, ALU done delayed 5 cycles -> o_ready low for all 5 cycles, token consumed only after RESULT.
- 2,ADD,3,MUL,4,EQ with ALU model:
  - With CALC_CHAIN_OPS_EN: two starts (2+3, then 5*4), display 20.
  - Without it: MUL ignored, one start computing 2+34, display 36.
- 9,SUB,EQ -> o_alu_a=9, o_alu_b=9, op=1. Then digit 4 in RESULT -> display 4, A_ENTRY.
